// File: rtl/key_event_sched.sv
// key_event_sched: per-key PRESS/LONG/REPEAT/RELEASE classifier
// sharing one event channel via round-robin arbiter and FIFO.
module key_event_sched #(
  parameter int N_KEYS     = 4,
  parameter int KEY_W      = 2,
  parameter int CNT_W      = 26,
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [N_KEYS-1:0] key_lvl,
  output logic              ev_valid,
  output logic [KEY_W-1:0]  ev_key,
  output logic [1:0]        ev_code,
  input  logic              ev_ready,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = KEY_W + 2;

  localparam logic [CNT_W-1:0] LONG_M1 =
    CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_M1 =
    CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] FCNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [1:0] C_PRESS   = 2'b00;
  localparam logic [1:0] C_LONG    = 2'b01;
  localparam logic [1:0] C_REPEAT  = 2'b10;
  localparam logic [1:0] C_RELEASE = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HELD = 2'd1;
  localparam logic [1:0] S_RPT  = 2'd2;

  logic [N_KEYS-1:0] key_d;
  logic [N_KEYS-1:0] rise;
  logic [1:0]        st_q  [N_KEYS];
  logic [1:0]        st_d  [N_KEYS];
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];

  logic [N_KEYS-1:0] emit;
  logic [1:0]        ecode [N_KEYS];
  logic [N_KEYS-1:0] pend_q;
  logic [1:0]        pcode_q [N_KEYS];
  logic [N_KEYS-1:0] gnt_oh;
  logic [N_KEYS-1:0] drop;

  logic [KEY_W-1:0]  last_q;
  logic [KEY_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              can_acc;
  logic              push;
  logic              pop;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       fcnt;

  assign rise = key_lvl & ~key_d;

  // Per-key level history, FSM state and hold counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      key_d <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        st_q[k]  <= S_IDLE;
        cnt_q[k] <= '0;
      end
    end else begin
      key_d <= key_lvl;
      for (int k = 0; k < N_KEYS; k++) begin
        st_q[k]  <= st_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Next state and counter; release beats thresholds.
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      st_d[k]  = st_q[k];
      cnt_d[k] = cnt_q[k];
      case (st_q[k])
        S_IDLE: begin
          if (rise[k]) begin
            st_d[k]  = S_HELD;
            cnt_d[k] = '0;
          end
        end
        S_HELD: begin
          if (!key_lvl[k]) begin
            st_d[k] = S_IDLE;
          end else if (cnt_q[k] == LONG_M1) begin
            st_d[k]  = S_RPT;
            cnt_d[k] = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
          end
        end
        S_RPT: begin
          if (!key_lvl[k]) begin
            st_d[k] = S_IDLE;
          end else if (cnt_q[k] == RPT_M1) begin
            cnt_d[k] = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
          end
        end
        default: st_d[k] = S_IDLE;
      endcase
    end
  end

  // Event emitted by each key this cycle.
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      emit[k]  = 1'b0;
      ecode[k] = C_PRESS;
      case (st_q[k])
        S_IDLE: begin
          if (rise[k]) begin
            emit[k]  = 1'b1;
            ecode[k] = C_PRESS;
          end
        end
        S_HELD: begin
          if (!key_lvl[k]) begin
            emit[k]  = 1'b1;
            ecode[k] = C_RELEASE;
          end else if (cnt_q[k] == LONG_M1) begin
            emit[k]  = 1'b1;
            ecode[k] = C_LONG;
          end
        end
        S_RPT: begin
          if (!key_lvl[k]) begin
            emit[k]  = 1'b1;
            ecode[k] = C_RELEASE;
          end else if (cnt_q[k] == RPT_M1) begin
            emit[k]  = 1'b1;
            ecode[k] = C_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop     = ev_valid & ev_ready;
  assign can_acc = (fcnt != FULL_CNT) | pop;
  assign push    = gnt_vld;

  // Round-robin search starting after the last grant.
  always_comb begin
    int j;
    logic [KEY_W-1:0] idx;
    j       = 0;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= N_KEYS; i++) begin
      j = int'(last_q) + i;
      if (j >= N_KEYS) j = j - N_KEYS;
      idx = KEY_W'(j);
      if (can_acc && !gnt_vld && pend_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // One-hot view of the grant for the slot logic.
  always_comb begin
    gnt_oh = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      gnt_oh[k] = gnt_vld && (gnt_idx == KEY_W'(k));
    end
  end

  assign drop = emit & pend_q & ~gnt_oh;

  // Pending slots and arbiter pointer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_q <= '0;
      last_q <= KEY_W'(N_KEYS - 1);
      for (int k = 0; k < N_KEYS; k++) begin
        pcode_q[k] <= C_PRESS;
      end
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (emit[k] && (!pend_q[k] || gnt_oh[k])) begin
          pend_q[k]  <= 1'b1;
          pcode_q[k] <= ecode[k];
        end else if (gnt_oh[k]) begin
          pend_q[k] <= 1'b0;
        end
      end
      if (gnt_vld) last_q <= gnt_idx;
    end
  end

  // Sticky overflow; a new drop outranks the clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf <= 1'b0;
    end else if (|drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Event FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= {gnt_idx, pcode_q[gnt_idx]};
        wptr      <= wptr + PTR_ONE;
      end
      if (pop) rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fcnt <= fcnt + FCNT_ONE;
        2'b01:   fcnt <= fcnt - FCNT_ONE;
        default: ;
      endcase
    end
  end

  assign ev_valid          = (fcnt != '0);
  assign {ev_key, ev_code} = mem[rptr];

endmodule

// File: tb/tb_key_event_sched.sv
// tb_key_event_sched: directed scenarios plus randomized
// run against an event-level reference model.
module tb_key_event_sched;

  localparam int N = 4;
  localparam int L = 8;
  localparam int R = 4;
  localparam int D = 4;
  localparam logic [1:0] PR = 2'b00;
  localparam logic [1:0] LG = 2'b01;
  localparam logic [1:0] RP = 2'b10;
  localparam logic [1:0] RL = 2'b11;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] key_lvl;
  logic       ev_valid;
  logic [1:0] ev_key;
  logic [1:0] ev_code;
  logic       ev_ready;
  logic       ovf;
  logic       ovf_clr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event_sched #(
    .N_KEYS(4), .KEY_W(2), .CNT_W(8),
    .LONG_CYC(L), .REPEAT_CYC(R), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .n_rst(n_rst), .key_lvl(key_lvl),
    .ev_valid(ev_valid), .ev_key(ev_key),
    .ev_code(ev_code), .ev_ready(ev_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct { int t; int k; int c; } ev_t;
  ev_t got [$];
  ev_t mon_e;

  always @(negedge clk) begin
    if (n_rst && ev_valid && ev_ready) begin
      mon_e.t = cyc;
      mon_e.k = int'(ev_key);
      mon_e.c = int'(ev_code);
      got.push_back(mon_e);
    end
  end

  bit         m_on;
  bit         m_pressed [N];
  int         m_tp [N];
  bit         m_prev [N];
  bit         m_pend [N];
  logic [1:0] m_pc [N];
  int         m_last;
  logic [3:0] m_q [$];
  bit         m_ovf;
  int         m_t;

  task automatic model_init();
    for (int k = 0; k < N; k++) begin
      m_pressed[k] = 0;
      m_tp[k] = 0;
      m_prev[k] = 0;
      m_pend[k] = 0;
      m_pc[k] = PR;
    end
    m_last = N - 1;
    m_q.delete();
    m_ovf = 0;
    m_t = 0;
  endtask

  task automatic model_step();
    bit can;
    bit pop;
    bit drop;
    int gnt;
    int d;
    bit ev [N];
    logic [1:0] ec [N];
    pop = (m_q.size() > 0) && ev_ready;
    can = (m_q.size() < D) || pop;
    gnt = -1;
    if (can) begin
      for (int i = 1; i <= N; i++) begin
        int j;
        j = (m_last + i) % N;
        if (gnt < 0 && m_pend[j]) gnt = j;
      end
    end
    for (int k = 0; k < N; k++) begin
      ev[k] = 0;
      ec[k] = PR;
      if (m_pressed[k]) begin
        if (!key_lvl[k]) begin
          ev[k] = 1;
          ec[k] = RL;
          m_pressed[k] = 0;
        end else begin
          d = m_t - m_tp[k];
          if (d == L) begin
            ev[k] = 1;
            ec[k] = LG;
          end else if (d > L && (d - L) % R == 0) begin
            ev[k] = 1;
            ec[k] = RP;
          end
        end
      end else if (key_lvl[k] && !m_prev[k]) begin
        ev[k] = 1;
        ec[k] = PR;
        m_pressed[k] = 1;
        m_tp[k] = m_t;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (gnt >= 0) begin
      m_q.push_back({2'(gnt), m_pc[gnt]});
      m_last = gnt;
    end
    drop = 0;
    for (int k = 0; k < N; k++) begin
      if (ev[k]) begin
        if (!m_pend[k] || k == gnt) begin
          m_pend[k] = 1;
          m_pc[k] = ec[k];
        end else begin
          drop = 1;
        end
      end else if (k == gnt) begin
        m_pend[k] = 0;
      end
    end
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    for (int k = 0; k < N; k++) m_prev[k] = key_lvl[k];
    m_t++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (m_on) model_step();
      #1;
    end
  endtask

  task automatic do_reset();
    m_on = 0;
    key_lvl = '0;
    ev_ready = 0;
    ovf_clr = 0;
    n_rst = 0;
    tick(2);
    n_rst = 1;
    tick(1);
    got.delete();
  endtask

  task automatic test_reset();
    m_on = 0;
    key_lvl = '0;
    ev_ready = 0;
    ovf_clr = 0;
    n_rst = 0;
    tick(2);
    tests++;
    if ({ev_valid, ev_key, ev_code, ovf} !== 6'b0) begin
      fails++;
      $display("FAIL reset_vals got v=%b k=%b c=%b o=%b want 0",
               ev_valid, ev_key, ev_code, ovf);
    end
    n_rst = 1;
    tick(4);
    tests++;
    if (ev_valid !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got v=%b o=%b want 0 0",
               ev_valid, ovf);
    end
  endtask

  task automatic test_short_press();
    int c0;
    int et [2];
    int ec [2];
    do_reset();
    ev_ready = 1;
    key_lvl = 4'b0001;
    c0 = cyc;
    tick(5);
    key_lvl = 4'b0000;
    tick(10);
    et = '{c0 + 2, c0 + 7};
    ec = '{PR, RL};
    tests++;
    if (got.size() !== 2) begin
      fails++;
      $display("FAIL short_count got %0d want 2", got.size());
    end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      tests++;
      if (got[i].t !== et[i] || got[i].k !== 0 ||
          got[i].c !== ec[i]) begin
        fails++;
        $display("FAIL short_ev%0d got t=%0d k=%0d c=%0d want t=%0d k=0 c=%0d",
                 i, got[i].t, got[i].k, got[i].c, et[i], ec[i]);
      end
    end
  endtask

  task automatic test_long_press();
    int c0;
    int et [5];
    int ec [5];
    do_reset();
    ev_ready = 1;
    key_lvl = 4'b0010;
    c0 = cyc;
    tick(20);
    key_lvl = 4'b0000;
    tick(8);
    et = '{c0 + 2, c0 + 10, c0 + 14, c0 + 18, c0 + 22};
    ec = '{PR, LG, RP, RP, RL};
    tests++;
    if (got.size() !== 5) begin
      fails++;
      $display("FAIL long_count got %0d want 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      tests++;
      if (got[i].t !== et[i] || got[i].k !== 1 ||
          got[i].c !== ec[i]) begin
        fails++;
        $display("FAIL long_ev%0d got t=%0d k=%0d c=%0d want t=%0d k=1 c=%0d",
                 i, got[i].t, got[i].k, got[i].c, et[i], ec[i]);
      end
    end
  endtask

  task automatic test_threshold_release();
    int c0;
    int et [2];
    int ec [2];
    do_reset();
    ev_ready = 1;
    key_lvl = 4'b0001;
    c0 = cyc;
    tick(8);
    key_lvl = 4'b0000;
    tick(6);
    et = '{c0 + 2, c0 + 10};
    ec = '{PR, RL};
    tests++;
    if (got.size() !== 2) begin
      fails++;
      $display("FAIL thresh_count got %0d want 2", got.size());
    end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      tests++;
      if (got[i].t !== et[i] || got[i].k !== 0 ||
          got[i].c !== ec[i]) begin
        fails++;
        $display("FAIL thresh_ev%0d got t=%0d k=%0d c=%0d want t=%0d k=0 c=%0d",
                 i, got[i].t, got[i].k, got[i].c, et[i], ec[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int c0;
    int ek [12];
    int ec [12];
    do_reset();
    ev_ready = 1;
    key_lvl = 4'b1011;
    c0 = cyc;
    tick(6);
    key_lvl = 4'b0000;
    tick(6);
    key_lvl = 4'b1011;
    tick(6);
    key_lvl = 4'b0000;
    tick(8);
    ek = '{0, 1, 3, 0, 1, 3, 0, 1, 3, 0, 1, 3};
    ec = '{PR, PR, PR, RL, RL, RL, PR, PR, PR, RL, RL, RL};
    tests++;
    if (got.size() !== 12) begin
      fails++;
      $display("FAIL rr_count got %0d want 12", got.size());
    end
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      tests++;
      if (got[i].k !== ek[i] || got[i].c !== ec[i]) begin
        fails++;
        $display("FAIL rr_ev%0d got k=%0d c=%0d want k=%0d c=%0d",
                 i, got[i].k, got[i].c, ek[i], ec[i]);
      end
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      tests++;
      if (got[i].t !== c0 + 2 + i) begin
        fails++;
        $display("FAIL rr_time%0d got %0d want %0d",
                 i, got[i].t, c0 + 2 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    int ek [8];
    int ec [8];
    do_reset();
    ev_ready = 0;
    key_lvl = 4'b1111;
    tick(6);
    tests++;
    if (ev_valid !== 1'b1 || {ev_key, ev_code} !== 4'b0000) begin
      fails++;
      $display("FAIL bp_head got v=%b k=%0d c=%0d want 1 0 0",
               ev_valid, ev_key, ev_code);
    end
    key_lvl = 4'b0000;
    tick(3);
    tests++;
    if (ev_valid !== 1'b1 || {ev_key, ev_code} !== 4'b0000 ||
        ovf !== 1'b0) begin
      fails++;
      $display("FAIL bp_hold got v=%b k=%0d c=%0d o=%b want 1 0 0 0",
               ev_valid, ev_key, ev_code, ovf);
    end
    key_lvl = 4'b1111;
    tick(2);
    tests++;
    if (ovf !== 1'b1 || {ev_key, ev_code} !== 4'b0000) begin
      fails++;
      $display("FAIL bp_ovf got o=%b k=%0d c=%0d want 1 0 0",
               ovf, ev_key, ev_code);
    end
    key_lvl = 4'b0000;
    tick(3);
    tests++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL bp_sticky got %b want 1", ovf);
    end
    ovf_clr = 1;
    tick(1);
    ovf_clr = 0;
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL bp_clr got %b want 0", ovf);
    end
    tick(2);
    ev_ready = 1;
    tick(12);
    ek = '{0, 1, 2, 3, 0, 1, 2, 3};
    ec = '{PR, PR, PR, PR, RL, RL, RL, RL};
    tests++;
    if (got.size() !== 8 || ev_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain got n=%0d v=%b want 8 0",
               got.size(), ev_valid);
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      tests++;
      if (got[i].k !== ek[i] || got[i].c !== ec[i]) begin
        fails++;
        $display("FAIL bp_ev%0d got k=%0d c=%0d want k=%0d c=%0d",
                 i, got[i].k, got[i].c, ek[i], ec[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    do_reset();
    ev_ready = 0;
    key_lvl = 4'b1111;
    tick(6);
    key_lvl = 4'b0100;
    tick(2);
    key_lvl = 4'b1100;
    tick(2);
    key_lvl = 4'b0100;
    tick(2);
    tests++;
    if (ev_valid !== 1'b1 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre got v=%b o=%b want 1 1",
               ev_valid, ovf);
    end
    #2;
    n_rst = 0;
    #1;
    tests++;
    if ({ev_valid, ev_key, ev_code, ovf} !== 6'b0) begin
      fails++;
      $display("FAIL rst_async got v=%b k=%b c=%b o=%b want 0",
               ev_valid, ev_key, ev_code, ovf);
    end
    tick(2);
    ev_ready = 1;
    got.delete();
    n_rst = 1;
    c0 = cyc;
    tick(6);
    tests++;
    if (got.size() !== 1) begin
      fails++;
      $display("FAIL rst_count got %0d want 1", got.size());
    end else if (got[0].k !== 2 || got[0].c !== PR ||
                 got[0].t !== c0 + 2) begin
      fails++;
      $display("FAIL rst_press got t=%0d k=%0d c=%0d want t=%0d k=2 c=0",
               got[0].t, got[0].k, got[0].c, c0 + 2);
    end
    key_lvl = 4'b0000;
    tick(4);
    tests++;
    if (got.size() !== 2) begin
      fails++;
      $display("FAIL rst_rel_count got %0d want 2", got.size());
    end else if (got[1].k !== 2 || got[1].c !== RL) begin
      fails++;
      $display("FAIL rst_rel got k=%0d c=%0d want k=2 c=3",
               got[1].k, got[1].c);
    end
  endtask

  task automatic test_random();
    m_on = 0;
    key_lvl = '0;
    ev_ready = 0;
    ovf_clr = 0;
    n_rst = 0;
    tick(2);
    n_rst = 1;
    model_init();
    m_on = 1;
    for (int n = 0; n < 1200; n++) begin
      tick(1);
      tests++;
      if (ev_valid !== (m_q.size() > 0) || ovf !== m_ovf ||
          (m_q.size() > 0 && {ev_key, ev_code} !== m_q[0])) begin
        fails++;
        $display("FAIL rand t=%0d got v=%b h=%h o=%b want v=%b h=%h o=%b",
                 n, ev_valid, {ev_key, ev_code}, ovf,
                 m_q.size() > 0,
                 (m_q.size() > 0) ? m_q[0] : 4'h0, m_ovf);
      end
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 13) == 0) key_lvl[k] = ~key_lvl[k];
      end
      if ((n % 200) < 120) ev_ready = ($urandom_range(0, 3) != 0);
      else ev_ready = ($urandom_range(0, 7) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
    end
    m_on = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    m_on = 0;
    test_reset();
    test_short_press();
    test_long_press();
    test_threshold_release();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
